// File: rtl/twiddle_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_seq_if
//  Description : Config-write, sweep-control and coefficient-stream bundle
//                between the control path and twiddle_seq.
//  Revision    : 1.0  initial release
// ============================================================================
interface twiddle_seq_if #(
   parameter int NBITS = 5,
   parameter int N     = 8
);
   localparam int ADDR_W = $clog2(N / 2);
   localparam int STAGES = $clog2(N);
   localparam int STG_W  = ($clog2(STAGES) < 1) ? 1 : $clog2(STAGES);

   // table write port
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [2*NBITS-1:0]     wr_data;
   logic                   wr_err;
   // sweep control
   logic                   start;
   logic                   inverse;
   logic                   busy;
   // coefficient stream
   logic                   coeff_valid;
   logic                   coeff_ready;
   logic [STG_W-1:0]       coeff_stage;
   logic                   coeff_last;
   logic [NBITS*N-1:0]     coeff_data;

   // control/config side and butterfly consumer side
   modport master (
      output wr_en, wr_addr, wr_data, start, inverse, coeff_ready,
      input  wr_err, busy, coeff_valid, coeff_stage, coeff_last, coeff_data
   );

   // sequencer side
   modport slave (
      input  wr_en, wr_addr, wr_data, start, inverse, coeff_ready,
      output wr_err, busy, coeff_valid, coeff_stage, coeff_last, coeff_data
   );
endinterface
`default_nettype wire

// File: rtl/twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_seq
//  Description : Run-time loadable table of N/2 complex twiddles W_N^k. Each
//                sweep emits one packed coefficient word per radix-2 stage to
//                the N/2 parallel butterflies, optionally conjugated (IFFT).
//  Revision    : 1.0  initial release
// ============================================================================
module twiddle_seq #(
   parameter int NBITS = 5,
   parameter int N     = 8
) (
   input  logic          clk,
   input  logic          rst,
   twiddle_seq_if.slave  bus
);
   localparam int LANES  = N / 2;
   localparam int STAGES = $clog2(N);
   localparam int ADDR_W = $clog2(LANES);
   localparam int STG_W  = ($clog2(STAGES) < 1) ? 1 : $clog2(STAGES);
   localparam int ENT_W  = 2 * NBITS;
   localparam int DATA_W = NBITS * N;

   localparam logic [NBITS-1:0] ONE        = NBITS'(2 ** (NBITS - 2));
   localparam logic [NBITS-1:0] IM_MIN     = {1'b1, {(NBITS-1){1'b0}}};
   localparam logic [NBITS-1:0] IM_MAX     = {1'b0, {(NBITS-1){1'b1}}};
   localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(STAGES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STG_W-1:0]    stage_q, stage_d;
   logic                inv_q, inv_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ENT_W-1:0]    tab_q [LANES];
   logic [ENT_W-1:0]    tab_d [LANES];
   logic [DATA_W-1:0]   calc_word;
   logic                handshake;

   // Table index feeding lane j in stage s: (j mod 2^s) << (STAGES-1-s)
   function automatic logic [ADDR_W-1:0] lane_index(input int j, input int s);
      int m;
      m = (j % (1 << s)) << (STAGES - 1 - s);
      return m[ADDR_W-1:0];
   endfunction

   // Conjugate an entry; the most negative imaginary value has no positive
   // twin, so it saturates to the largest positive value instead of wrapping.
   function automatic logic [ENT_W-1:0] lane_word(input logic [ENT_W-1:0] e,
                                                  input logic inv);
      logic [NBITS-1:0] im;
      im = e[NBITS-1:0];
      if (inv) begin
         im = (im == IM_MIN) ? IM_MAX : -im;
      end
      return {e[ENT_W-1:NBITS], im};
   endfunction

   assign handshake = (state_q == S_HOLD) && bus.coeff_ready;

   // Gather the coefficient word for the current stage from the table
   always_comb begin
      calc_word = '0;
      for (int j = 0; j < LANES; j++) begin
         calc_word[j*ENT_W +: ENT_W] =
            lane_word(tab_q[lane_index(j, int'(stage_q))], inv_q);
      end
   end

   // Next-state logic: sweep sequencing, table writes and write-error pulse
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      inv_d   = inv_q;
      data_d  = data_q;
      err_d   = 1'b0;
      tab_d   = tab_q;
      case (state_q)
         S_IDLE: begin
            // a write issued together with start lands first, so the sweep
            // reads the new entry during CALC
            if (bus.wr_en) begin
               tab_d[bus.wr_addr] = bus.wr_data;
            end
            if (bus.start) begin
               state_d = S_CALC;
               stage_d = '0;
               inv_d   = bus.inverse;
            end
         end
         S_CALC: begin
            err_d   = bus.wr_en;
            data_d  = calc_word;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            err_d = bus.wr_en;
            if (handshake) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = S_IDLE;
                  stage_d = '0;
               end else begin
                  state_d = S_CALC;
                  stage_d = stage_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            stage_d = '0;
         end
      endcase
   end

   // State, stream and table registers with synchronous reset to unity table
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         inv_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         for (int i = 0; i < LANES; i++) begin
            tab_q[i] <= {ONE, {NBITS{1'b0}}};
         end
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         inv_q   <= inv_d;
         err_q   <= err_d;
         data_q  <= data_d;
         tab_q   <= tab_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.coeff_valid = (state_q == S_HOLD);
   assign bus.coeff_last  = (state_q == S_HOLD) && (stage_q == LAST_STAGE);
   assign bus.coeff_stage = stage_q;
   assign bus.coeff_data  = data_q;
   assign bus.wr_err      = err_q;

endmodule
`default_nettype wire
